// File: rtl/drive_pkg.sv
// ---------------------------------------------------------------------------
// drive_pkg
// Shared types and helpers for the drive arbiter and its output shaper.
//   drive_cmd_t   : 3-bit motor drive code (Stop .. Fast_right)
//   mode_t        : arbiter mode (DISARMED / AUTO / MANUAL)
//   shape_state_t : output shaper state (normal running / reversal gap)
//   IR_RELEASE    : NEC command byte that hands control back to AUTO
//   IR_MAX_DRIVE  : highest NEC command byte that is a drive request
//   is_left(), is_right(), sanitize()
// ---------------------------------------------------------------------------
package drive_pkg;

    typedef enum logic [2:0] {
        CMD_STOP       = 3'd0,
        CMD_FAST_LEFT  = 3'd1,
        CMD_LEFT       = 3'd2,
        CMD_STRAIGHT   = 3'd3,
        CMD_RIGHT      = 3'd4,
        CMD_FAST_RIGHT = 3'd5
    } drive_cmd_t;

    typedef enum logic [1:0] {
        MODE_DISARMED = 2'd0,
        MODE_AUTO     = 2'd1,
        MODE_MANUAL   = 2'd2
    } mode_t;

    typedef enum logic {
        SHAPE_RUN = 1'b0,
        SHAPE_GAP = 1'b1
    } shape_state_t;

    localparam logic [7:0] IR_RELEASE   = 8'hFF;
    localparam logic [7:0] IR_MAX_DRIVE = 8'h05;

    function automatic logic is_left(input drive_cmd_t cmd);
        return (cmd == CMD_FAST_LEFT) || (cmd == CMD_LEFT);
    endfunction

    function automatic logic is_right(input drive_cmd_t cmd);
        return (cmd == CMD_RIGHT) || (cmd == CMD_FAST_RIGHT);
    endfunction

    // Codes 6 and 7 are not valid drive codes; they must never reach the motors.
    function automatic drive_cmd_t sanitize(input logic [2:0] raw);
        return (raw > 3'd5) ? CMD_STOP : drive_cmd_t'(raw);
    endfunction

endpackage

// File: rtl/drive_arbiter_if.sv
// ---------------------------------------------------------------------------
// drive_arbiter_if
// Bundles the sensor requests going into the arbiter and the shaped drive
// command coming out of it.
//   vis_command/vis_valid : vision drive request and its qualifier
//   clap / whistle        : single-cycle disarm / arm pulses
//   ir_command/ir_valid   : NEC frame and its single-cycle strobe
//   drive_command/valid   : registered motor command and qualifier
//   mode                  : current arbiter mode
// Modports: master = request source side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface drive_arbiter_if;

    logic [2:0]  vis_command;
    logic        vis_valid;
    logic        clap;
    logic        whistle;
    logic [31:0] ir_command;
    logic        ir_valid;
    logic [2:0]  drive_command;
    logic        valid;
    logic [1:0]  mode;

    modport master (
        output vis_command, vis_valid, clap, whistle, ir_command, ir_valid,
        input  drive_command, valid, mode
    );

    modport slave (
        input  vis_command, vis_valid, clap, whistle, ir_command, ir_valid,
        output drive_command, valid, mode
    );

endinterface

// File: rtl/drive_output_shaper.sv
// ---------------------------------------------------------------------------
// drive_output_shaper
// Turns the arbiter's per-cycle target into the registered drive command.
// Stop always goes through on the next cycle. A left<->right reversal is
// broken up by GAP_CYCLES cycles of Stop. Any other change between two
// non-Stop codes waits until the current code has been held MIN_HOLD cycles,
// unless bypass_hold is set (manual driving).
//   clk, reset    : clock, asynchronous active-high reset
//   target        : requested drive code (already sanitised)
//   bypass_hold   : skip the minimum hold time (not the reversal gap)
//   drive_command : registered drive code
// ---------------------------------------------------------------------------
module drive_output_shaper
    import drive_pkg::*;
#(
    parameter int unsigned MIN_HOLD   = 2_500_000,
    parameter int unsigned GAP_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  drive_cmd_t target,
    input  logic       bypass_hold,
    output drive_cmd_t drive_command
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYCLES);

    shape_state_t      state_q, state_d;
    drive_cmd_t        drive_q, drive_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              reversal;

    assign reversal = (is_left(drive_q) && is_right(target)) ||
                      (is_right(drive_q) && is_left(target));

    // State, output and both counters live in one register bank so a reset
    // in the middle of a gap or a hold drops everything back at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SHAPE_RUN;
            drive_q <= CMD_STOP;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            drive_q <= drive_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic. Stop wins over everything, including a running gap.
    // The gap counter holds the number of Stop cycles already on the output,
    // so the gap ends on the edge where it has reached GAP_CYCLES; whatever
    // target is current then is applied directly, since the output is Stop.
    // Deferred changes keep re-reading the target, so the latest request
    // is the one released once the hold time is met.
    always_comb begin
        state_d = state_q;
        drive_d = drive_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        if (target == CMD_STOP) begin
            state_d = SHAPE_RUN;
            drive_d = CMD_STOP;
            hold_d  = '0;
            gap_d   = '0;
        end else if (state_q == SHAPE_GAP) begin
            if (gap_q >= GAP_MAX) begin
                state_d = SHAPE_RUN;
                drive_d = target;
                hold_d  = '0;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end else if (target == drive_q) begin
            if (hold_q < HOLD_MAX) begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end else if (drive_q == CMD_STOP) begin
            drive_d = target;
            hold_d  = '0;
        end else if (reversal) begin
            state_d = SHAPE_GAP;
            drive_d = CMD_STOP;
            hold_d  = '0;
            gap_d   = GAP_W'(1);
        end else if (bypass_hold || (hold_q >= HOLD_MAX)) begin
            drive_d = target;
            hold_d  = '0;
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end
    end

    assign drive_command = drive_q;

endmodule

// File: rtl/drive_arbiter.sv
// ---------------------------------------------------------------------------
// drive_arbiter
// Chooses who drives the motors (nobody, vision, or the IR remote), decodes
// NEC frames, watches the vision stream for silence and feeds the chosen
// target through the output shaper.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : drive_arbiter_if.slave (sensor requests in, drive_command,
//           valid and mode out)
// All parameters must be at least 1.
// ---------------------------------------------------------------------------
module drive_arbiter
    import drive_pkg::*;
#(
    parameter int unsigned MIN_HOLD    = 2_500_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000,
    parameter int unsigned IR_HOLD     = 25_000_000,
    parameter int unsigned VIS_TIMEOUT = 10_000_000
) (
    input logic            clk,
    input logic            reset,
    drive_arbiter_if.slave bus
);

    localparam int IR_W = $clog2(IR_HOLD + 1);
    localparam int WD_W = $clog2(VIS_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(VIS_TIMEOUT);

    mode_t           mode_q, mode_d;
    logic            ir_load;
    logic [IR_W-1:0] ir_timer;
    drive_cmd_t      ir_target;
    logic [WD_W-1:0] vis_wdog;
    drive_cmd_t      target, target_q;
    drive_cmd_t      shaped_command;
    logic            valid_q;

    logic [7:0] ir_byte;
    logic       ir_ok, ir_drive, ir_release;
    logic       unused_ir_hi;

    // A frame only counts when the command byte and its complement agree.
    assign ir_byte      = bus.ir_command[15:8];
    assign ir_ok        = bus.ir_valid && (bus.ir_command[7:0] == ~ir_byte);
    assign ir_drive     = ir_ok && (ir_byte <= IR_MAX_DRIVE);
    assign ir_release   = ir_ok && (ir_byte == IR_RELEASE);
    assign unused_ir_hi = ^bus.ir_command[31:16];

    // Mode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_DISARMED;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode transitions, highest priority first: clap, IR, whistle. The IR
    // timer is treated as reaching zero on the edge that would take it from
    // 1 to 0, so MANUAL lasts exactly IR_HOLD cycles after the last frame.
    always_comb begin
        mode_d  = mode_q;
        ir_load = 1'b0;
        if (bus.clap) begin
            mode_d = MODE_DISARMED;
        end else if (ir_drive) begin
            mode_d  = MODE_MANUAL;
            ir_load = 1'b1;
        end else if ((mode_q == MODE_MANUAL) && (ir_release || (ir_timer <= IR_W'(1)))) begin
            mode_d = MODE_AUTO;
        end else if ((mode_q == MODE_DISARMED) && bus.whistle) begin
            mode_d = MODE_AUTO;
        end
    end

    // IR target and manual-mode timer. Each accepted drive frame reloads the
    // timer; it only counts down while we are actually in MANUAL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_timer  <= '0;
            ir_target <= CMD_STOP;
        end else if (ir_load) begin
            ir_timer  <= IR_W'(IR_HOLD);
            ir_target <= sanitize(ir_byte[2:0]);
        end else if ((mode_q == MODE_MANUAL) && (ir_timer != '0)) begin
            ir_timer <= ir_timer - IR_W'(1);
        end
    end

    // Vision watchdog: counts cycles since the last vis_valid and sticks at
    // VIS_TIMEOUT so it never wraps back into the "fresh" range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vis_wdog <= '0;
        end else if (bus.vis_valid) begin
            vis_wdog <= '0;
        end else if (vis_wdog != WD_MAX) begin
            vis_wdog <= vis_wdog + WD_W'(1);
        end
    end

    // Target selection from the registered mode. In AUTO a missing vis_valid
    // keeps the previous target until the watchdog has expired.
    always_comb begin
        target = CMD_STOP;
        case (mode_q)
            MODE_MANUAL: target = ir_target;
            MODE_AUTO: begin
                if (bus.vis_valid) begin
                    target = sanitize(bus.vis_command);
                end else if (vis_wdog == WD_MAX) begin
                    target = CMD_STOP;
                end else begin
                    target = target_q;
                end
            end
            default: target = CMD_STOP;
        endcase
    end

    // Remember the last target and raise valid on the first edge out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= CMD_STOP;
            valid_q  <= 1'b0;
        end else begin
            target_q <= target;
            valid_q  <= 1'b1;
        end
    end

    drive_output_shaper #(
        .MIN_HOLD  (MIN_HOLD),
        .GAP_CYCLES(GAP_CYCLES)
    ) u_shaper (
        .clk          (clk),
        .reset        (reset),
        .target       (target),
        .bypass_hold  (mode_q == MODE_MANUAL),
        .drive_command(shaped_command)
    );

    assign bus.drive_command = shaped_command;
    assign bus.valid         = valid_q;
    assign bus.mode          = mode_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// ---------------------------------------------------------------------------
// tb_drive_arbiter
// Drives drive_arbiter with small timing parameters. Each stimulus cycle
// pushes the drive_command/mode expected after the next clock edge onto a
// scoreboard queue; a monitor pops and compares one entry per edge.
// ---------------------------------------------------------------------------
module tb_drive_arbiter;

    typedef struct packed {
        int         step;
        logic [2:0] drive;
        logic [1:0] mode;
    } expect_t;

    logic clk = 1'b0;
    logic reset;
    int   check_count = 0;
    int   pass_count  = 0;
    int   step_idx    = 0;

    expect_t sb_queue[$];

    drive_arbiter_if bus();

    drive_arbiter #(
        .MIN_HOLD   (4),
        .GAP_CYCLES (3),
        .IR_HOLD    (10),
        .VIS_TIMEOUT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Drives one cycle of inputs and queues what the outputs must be after
    // the edge that samples them. Pulses last exactly this one cycle.
    task automatic applyStimulus(input logic vv, input logic [2:0] vc, input logic cl, input logic wh,
                                 input logic iv, input logic [31:0] ic,
                                 input logic [2:0] exp_drive, input logic [1:0] exp_mode);
        expect_t item;
        @(negedge clk);
        bus.vis_valid   = vv;
        bus.vis_command = vc;
        bus.clap        = cl;
        bus.whistle     = wh;
        bus.ir_valid    = iv;
        bus.ir_command  = ic;
        step_idx++;
        item.step  = step_idx;
        item.drive = exp_drive;
        item.mode  = exp_mode;
        sb_queue.push_back(item);
    endtask

    task automatic visStep(input logic [2:0] vc, input logic [2:0] exp_drive, input logic [1:0] exp_mode);
        applyStimulus(1'b1, vc, 1'b0, 1'b0, 1'b0, 32'h0, exp_drive, exp_mode);
    endtask

    task automatic irStep(input logic [31:0] ic, input logic [2:0] exp_drive, input logic [1:0] exp_mode);
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, ic, exp_drive, exp_mode);
    endtask

    // Scoreboard monitor: samples 1 time unit after each rising edge.
    always begin : scoreboard_monitor
        expect_t item;
        @(posedge clk);
        #1;
        if (sb_queue.size() > 0) begin
            item = sb_queue.pop_front();
            checkOutput($sformatf("drive@%0d", item.step), {29'b0, bus.drive_command}, {29'b0, item.drive});
            checkOutput($sformatf("mode@%0d", item.step), {30'b0, bus.mode}, {30'b0, item.mode});
            checkOutput($sformatf("valid@%0d", item.step), {31'b0, bus.valid}, 32'd1);
        end
    end

    initial begin
        reset           = 1'b1;
        bus.vis_valid   = 1'b0;
        bus.vis_command = 3'd0;
        bus.clap        = 1'b0;
        bus.whistle     = 1'b0;
        bus.ir_valid    = 1'b0;
        bus.ir_command  = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_drive", {29'b0, bus.drive_command}, 32'd0);
        checkOutput("reset_mode", {30'b0, bus.mode}, 32'd0);
        checkOutput("reset_valid", {31'b0, bus.valid}, 32'd0);
        reset = 1'b0;

        // Arm with a whistle, vision asks for Straight.
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 2'd1);
        visStep(3'd3, 3'd3, 2'd1);

        // Hold time: 3 -> 2 waits four cycles.
        for (int i = 0; i < 4; i++) visStep(3'd2, 3'd3, 2'd1);
        visStep(3'd2, 3'd2, 2'd1);
        // Stop mid-hold goes through immediately; Stop -> 3 is immediate too.
        visStep(3'd3, 3'd2, 2'd1);
        visStep(3'd0, 3'd0, 2'd1);
        visStep(3'd3, 3'd3, 2'd1);
        // Latest deferred target wins at release (5 is skipped).
        visStep(3'd2, 3'd3, 2'd1);
        visStep(3'd5, 3'd3, 2'd1);
        visStep(3'd1, 3'd3, 2'd1);
        visStep(3'd1, 3'd3, 2'd1);
        visStep(3'd1, 3'd1, 2'd1);

        // Left group change 1 -> 2 is a normal held change.
        for (int i = 0; i < 4; i++) visStep(3'd2, 3'd1, 2'd1);
        visStep(3'd2, 3'd2, 2'd1);
        for (int i = 0; i < 5; i++) visStep(3'd2, 3'd2, 2'd1);
        // Reversal 2 -> 4: three Stop cycles, then 4.
        for (int i = 0; i < 3; i++) visStep(3'd4, 3'd0, 2'd1);
        visStep(3'd4, 3'd4, 2'd1);
        // Reversal 4 -> 1 abandoned by Stop; next request is not gapped.
        visStep(3'd1, 3'd0, 2'd1);
        visStep(3'd1, 3'd0, 2'd1);
        visStep(3'd0, 3'd0, 2'd1);
        visStep(3'd1, 3'd1, 2'd1);
        // Reversal 1 -> 5, target back to left mid-gap: gap still completes.
        visStep(3'd5, 3'd0, 2'd1);
        visStep(3'd2, 3'd0, 2'd1);
        visStep(3'd2, 3'd0, 2'd1);
        visStep(3'd2, 3'd2, 2'd1);
        // Code 7 is Stop.
        visStep(3'd7, 3'd0, 2'd1);
        visStep(3'd0, 3'd0, 2'd1);

        // IR drive frame (Fast_left), MANUAL for exactly 10 cycles.
        irStep(32'h0000_01FE, 3'd0, 2'd2);
        for (int i = 0; i < 9; i++) visStep(3'd0, 3'd1, 2'd2);
        visStep(3'd0, 3'd1, 2'd1);
        visStep(3'd0, 3'd0, 2'd1);
        // Bad complement and a non-drive byte are ignored.
        irStep(32'h0000_0101, 3'd0, 2'd1);
        irStep(32'h0000_06F9, 3'd0, 2'd1);
        visStep(3'd0, 3'd0, 2'd1);
        // Manual 3 then 5: the hold time is bypassed. Release returns to AUTO.
        irStep(32'h0000_03FC, 3'd0, 2'd2);
        visStep(3'd0, 3'd3, 2'd2);
        irStep(32'h0000_05FA, 3'd3, 2'd2);
        visStep(3'd0, 3'd5, 2'd2);
        irStep(32'h0000_FF00, 3'd5, 2'd1);
        visStep(3'd0, 3'd0, 2'd1);

        // Clap beats a simultaneous IR drive frame.
        visStep(3'd3, 3'd3, 2'd1);
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 32'h0000_04FB, 3'd3, 2'd0);
        visStep(3'd3, 3'd0, 2'd0);
        visStep(3'd3, 3'd0, 2'd0);

        // Vision watchdog: 8 silent cycles keep 3, the next forces Stop.
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 2'd1);
        visStep(3'd3, 3'd3, 2'd1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 3'd3, 2'd1);
        applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 2'd1);
        applyStimulus(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 32'h0, 3'd0, 2'd1);
        visStep(3'd3, 3'd3, 2'd1);
        visStep(3'd2, 3'd3, 2'd1);

        // Reset in the middle of a hold clears outputs without a clock edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midreset_drive", {29'b0, bus.drive_command}, 32'd0);
        checkOutput("midreset_mode", {30'b0, bus.mode}, 32'd0);
        checkOutput("midreset_valid", {31'b0, bus.valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 2'd1);
        visStep(3'd3, 3'd3, 2'd1);

        @(negedge clk);
        checkOutput("sb_drain", sb_queue.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
Arbitrates motor drive requests from the vision path, the audio classifier (clap/whistle) and the IR remote, and produces the single registered drive_command for the motor controller. It owns arming/disarming and manual override. It also shapes the output: minimum hold time on steering changes and a forced Stop gap on left/right reversals. It sits between the per-sensor decision blocks and the motor PWM driver.

Parameters:
MIN_HOLD, 2_500_000, minimum cycles a non-Stop command is held before it may change to another non-Stop command (50 ms at 50 MHz).
GAP_CYCLES, 5_000_000, Stop cycles inserted on a left↔right reversal.
IR_HOLD, 25_000_000, cycles MANUAL mode persists after the last valid IR drive frame.
VIS_TIMEOUT, 10_000_000, cycles without vis_valid before AUTO forces Stop.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vis_command  in  3  vision drive request (0 Stop, 1 Fast_left, 2 Left, 3 Straight, 4 Right, 5 Fast_right)
vis_valid  in  1  vis_command qualifier, sampled each cycle
clap  in  1  single-cycle pulse: disarm request
whistle  in  1  single-cycle pulse: arm request
ir_command  in  32  NEC frame; [15:8] command byte, [7:0] its complement
ir_valid  in  1  single-cycle pulse, ir_command valid
drive_command  out  3  registered drive code, same encoding as vis_command
valid  out  1  output qualifier
mode  out  2  0 DISARMED, 1 AUTO, 2 MANUAL

Behaviour:
- Reset (async assert, sync release): mode=DISARMED, drive_command=0, valid=0, all counters 0, pending target=Stop. valid goes to 1 on the first clk edge after reset deasserts and stays 1.
- Codes 6 and 7, from any source, are treated as Stop.
- IR decode: a frame is accepted only if ir_valid=1 and ir_command[7:0] == ~ir_command[15:8]. Byte 0x00–0x05 is a drive request. Byte 0xFF means release. All other bytes are ignored.
- Mode FSM, one transition per cycle. Priority for simultaneous events: clap > IR > whistle > vision.
  - Any state + clap → DISARMED.
  - DISARMED/AUTO + accepted IR drive frame → MANUAL, target=byte, IR timer loaded with IR_HOLD.
  - MANUAL + accepted IR drive frame → stays MANUAL, target updated, timer reloaded.
  - MANUAL + IR release or IR timer reaching 0 → AUTO.
  - DISARMED + whistle → AUTO. Whistle in AUTO/MANUAL is a no-op.
- Target selection: DISARMED → Stop. MANUAL → last IR byte. AUTO → vis_command when vis_valid, else the previous target.
- Vision watchdog: counter cleared on every vis_valid and incremented otherwise, saturating at VIS_TIMEOUT. In AUTO at saturation, target=Stop until the next vis_valid.
- Output shaper, latency 1 cycle from target change to drive_command:
  - Target Stop: applied next cycle unconditionally, overriding both hold and gap.
  - Left group {1,2} ↔ right group {4,5}: drive_command=0 for exactly GAP_CYCLES cycles, then the target current at gap end, re-evaluated by the same rules. If the target becomes Stop mid-gap, Stop is held and the gap is abandoned. If the target returns to the original group mid-gap, the gap still completes.
  - Any other non-Stop change: deferred until the hold counter ≥ MIN_HOLD. The latest target wins at release, not the first. MANUAL targets bypass the hold but not the gap.
  - The hold counter restarts at every drive_command change to a non-Stop value.
- Counters: width $clog2(max+1), saturate with no wrap. Parameters must be ≥1.
- Reset asserted mid-gap or mid-hold: immediately returns to the reset values.

Decomposition:
- Shared package drive_pkg:
  - drive_cmd_t enum (Stop..Fast_right, 3 bits)
  - mode_t enum
  - IR_RELEASE=8'hFF
  - functions is_left(), is_right(), sanitize() (6/7→Stop)
- One sub-module, drive_output_shaper: hold counter, gap counter and output register. Inputs are target and bypass_hold; output is drive_command. The mode FSM, IR decode and watchdog stay in drive_arbiter.

Test Plan:
Bench overrides: MIN_HOLD=4, GAP_CYCLES=3, IR_HOLD=10, VIS_TIMEOUT=8.
1. Reset release, whistle at cycle 0, vis_valid=1 with vis_command=3 continuously → mode=1 after cycle 0, drive_command=3 by cycle 2, valid=1.
2. Output 3 just applied, vis=2 at the next cycle → drive_command stays 3 for 4 cycles, then 2. Repeat with vis=0 mid-hold → 0 on the next cycle.
3. Output 2 held past MIN_HOLD, vis → 4 → drive_command=0 for exactly 3 cycles, then 4. vis → 0 during the gap → stays 0.
4. ir_command=32'h0000_01FE → mode=2, drive_command=1 next cycle. No further IR → mode=1 after 10 cycles. Frame 32'h0000_0101 → ignored. Frame 32'h0000_FF00 → mode=1.
5. ir_valid with 32'h0000_04FB and clap in the same cycle → mode=0, drive_command=0.
6. In AUTO at output 3, hold vis_valid=0 → drive_command=0 after 8 idle cycles plus latency. Next vis_valid with vis=3 → 3. Assert reset mid-sequence → drive_command=0, mode=0 immediately.
